// File: rtl/boundary_tracer_pkg.sv
// boundary_tracer_pkg
// Shared definitions for the boundary tracer: controller state encoding,
// Freeman direction constants, per-direction unit steps and the rule that
// picks where the counter-clockwise neighbour search begins.
// No ports (package).
package boundary_tracer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_LOAD,
    ST_SEARCH,
    ST_EMIT,
    ST_DONE
  } state_e;

  // Freeman codes; N points towards smaller row numbers.
  localparam logic [2:0] DIR_E  = 3'd0;
  localparam logic [2:0] DIR_NE = 3'd1;
  localparam logic [2:0] DIR_N  = 3'd2;
  localparam logic [2:0] DIR_NW = 3'd3;
  localparam logic [2:0] DIR_W  = 3'd4;
  localparam logic [2:0] DIR_SW = 3'd5;
  localparam logic [2:0] DIR_S  = 3'd6;
  localparam logic [2:0] DIR_SE = 3'd7;

  function automatic int dir_dx(input logic [2:0] d);
    case (d)
      DIR_E, DIR_NE, DIR_SE: return 1;
      DIR_NW, DIR_W, DIR_SW: return -1;
      DIR_N, DIR_S:          return 0;
      default:               return 0;
    endcase
  endfunction

  function automatic int dir_dy(input logic [2:0] d);
    case (d)
      DIR_NE, DIR_N, DIR_NW: return -1;
      DIR_SW, DIR_S, DIR_SE: return 1;
      DIR_E, DIR_W:          return 0;
      default:               return 0;
    endcase
  endfunction

  // Backing off from the arrival direction guarantees the search starts on
  // a background pixel, so the first foreground hit lies on the outer boundary.
  function automatic logic [2:0] first_dir(input logic [2:0] d_prev);
    return d_prev[0] ? (d_prev + 3'd6) : (d_prev + 3'd7);
  endfunction

endpackage

// File: rtl/boundary_tracer_sel.sv
// moore_neighbour_sel
// Combinational Moore-neighbour selector: walks the 8 neighbours
// counter-clockwise starting at 'first' and reports the first foreground one.
// Ports:
//   nbr   in  8  neighbour pixels, bit k = pixel in Freeman direction k
//   first in  3  direction where the walk starts
//   found out 1  some neighbour is foreground
//   d     out 3  direction of the first foreground neighbour
module moore_neighbour_sel
  import boundary_tracer_pkg::*;
(
  input  logic [7:0] nbr,
  input  logic [2:0] first,
  output logic       found,
  output logic [2:0] d
);

  always_comb begin
    logic [2:0] dir;
    dir   = first;
    found = 1'b0;
    d     = first;
    for (int k = 0; k < 8; k++) begin
      dir = first + 3'(k);
      if (!found && nbr[dir]) begin
        found = 1'b1;
        d     = dir;
      end
    end
  end

endmodule

// File: rtl/boundary_tracer.sv
// boundary_tracer
// Scans a binary image row by row for the first foreground pixel, then
// follows the outer boundary of that object with Moore-neighbour tracing,
// streaming Freeman codes and reporting perimeter counts and twice the area.
// Ports:
//   Clk, reset_n           clock, asynchronous active-low reset
//   start                  begin a trace (honoured in IDLE/DONE only)
//   mem_rd, mem_addr       row read strobe / row address
//   mem_data               row data, one cycle after mem_rd; column c at [IMG_W-1-c]
//   code_valid/code_ready  chain-code handshake, code = Freeman direction
//   start_x, start_y       first foreground pixel in raster order
//   perim_even, perim_odd  number of straight / diagonal codes
//   area2                  |2 x polygon area| over pixel centres
//   busy, done, error      status
module boundary_tracer
  import boundary_tracer_pkg::*;
#(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int COORD_W = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H),
  parameter int PERIM_W = 16,
  parameter int AREA_W  = 2 * COORD_W + 2
)(
  input  logic                     Clk,
  input  logic                     reset_n,
  input  logic                     start,
  output logic                     mem_rd,
  output logic [$clog2(IMG_H)-1:0] mem_addr,
  input  logic [IMG_W-1:0]         mem_data,
  output logic                     code_valid,
  input  logic                     code_ready,
  output logic [2:0]               code,
  output logic [COORD_W-1:0]       start_x,
  output logic [COORD_W-1:0]       start_y,
  output logic [PERIM_W-1:0]       perim_even,
  output logic [PERIM_W-1:0]       perim_odd,
  output logic [AREA_W-1:0]        area2,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int ADDR_W = $clog2(IMG_H);
  // Headroom for partial shoelace sums, which can exceed the final area.
  localparam int ACC_W  = AREA_W + 2;

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         scan_row_q, scan_row_d;
  logic                      scan_last_q, scan_last_d;
  logic                      rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0]         rd_row_q, rd_row_d;
  logic [1:0]                ld_q, ld_d;
  logic [7:0]                nbr_q, nbr_d;
  logic [COORD_W-1:0]        cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [COORD_W-1:0]        start_x_q, start_x_d, start_y_q, start_y_d;
  logic [2:0]                d_prev_q, d_prev_d;
  logic [2:0]                code_q, code_d;
  logic [2:0]                first_code_q, first_code_d;
  logic                      emitted_q, emitted_d;
  logic [PERIM_W-1:0]        perim_even_q, perim_even_d, perim_odd_q, perim_odd_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [AREA_W-1:0]         area2_q, area2_d;
  logic                      done_q, done_d, error_q, error_d;

  logic                      hit_found;
  logic [COORD_W-1:0]        hit_col;
  logic [2:0]                search_first;
  logic                      sel_found;
  logic [2:0]                sel_d;

  // Pixel fetch with everything left or right of the image reading as zero.
  function automatic logic pix(input logic [IMG_W-1:0] row, input int col);
    logic [IMG_W-1:0] sh;
    sh = '0;
    if (col >= 0 && col < IMG_W) sh = row >> (IMG_W - 1 - col);
    return sh[0];
  endfunction

  // Leftmost set pixel of the row currently on mem_data.
  always_comb begin
    hit_found = 1'b0;
    hit_col   = '0;
    for (int c = 0; c < IMG_W; c++) begin
      if (!hit_found && mem_data[IMG_W-1-c]) begin
        hit_found = 1'b1;
        hit_col   = COORD_W'(c);
      end
    end
  end

  assign search_first = first_dir(d_prev_q);

  moore_neighbour_sel u_sel (
    .nbr   (nbr_q),
    .first (search_first),
    .found (sel_found),
    .d     (sel_d)
  );

  // Controller: scan for the start pixel, then loop LOAD -> SEARCH -> EMIT
  // once per chain code. Every register holds unless a state updates it.
  always_comb begin
    int         ry, cx, dx, dy;
    logic [2:0] cap;

    state_d      = state_q;
    scan_row_d   = scan_row_q;
    scan_last_d  = scan_last_q;
    rd_vld_d     = 1'b0;
    rd_row_d     = rd_row_q;
    ld_d         = ld_q;
    nbr_d        = nbr_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    start_x_d    = start_x_q;
    start_y_d    = start_y_q;
    d_prev_d     = d_prev_q;
    code_d       = code_q;
    first_code_d = first_code_q;
    emitted_d    = emitted_q;
    perim_even_d = perim_even_q;
    perim_odd_d  = perim_odd_q;
    acc_d        = acc_q;
    area2_d      = area2_q;
    done_d       = done_q;
    error_d      = error_q;
    mem_rd       = 1'b0;
    mem_addr     = '0;
    ry           = 0;
    cx           = int'(cur_x_q);
    dx           = 0;
    dy           = 0;
    cap          = '0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_SCAN;
          scan_row_d   = '0;
          scan_last_d  = 1'b0;
          emitted_d    = 1'b0;
          perim_even_d = '0;
          perim_odd_d  = '0;
          acc_d        = '0;
          area2_d      = '0;
          done_d       = 1'b0;
          error_d      = 1'b0;
        end
      end

      ST_SCAN: begin
        // Issue one row per cycle while checking the row issued last cycle.
        if (!scan_last_q) begin
          mem_rd      = 1'b1;
          mem_addr    = scan_row_q;
          rd_vld_d    = 1'b1;
          rd_row_d    = scan_row_q;
          scan_row_d  = scan_row_q + 1'b1;
          scan_last_d = (scan_row_q == ADDR_W'(IMG_H - 1));
        end
        if (rd_vld_q && hit_found) begin
          start_x_d = hit_col;
          start_y_d = COORD_W'(rd_row_q);
          cur_x_d   = hit_col;
          cur_y_d   = COORD_W'(rd_row_q);
          d_prev_d  = DIR_SE;
          ld_d      = 2'd0;
          state_d   = ST_LOAD;
        end else if (rd_vld_q && rd_row_q == ADDR_W'(IMG_H - 1)) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_LOAD: begin
        // Phases 0..2 request rows y-1, y, y+1; phases 1..3 capture the
        // three columns around cur_x of the row requested one phase earlier.
        if (ld_q != 2'd3) begin
          ry = int'(cur_y_q) - 1 + int'(ld_q);
          if (ry >= 0 && ry < IMG_H) begin
            mem_rd   = 1'b1;
            mem_addr = ADDR_W'(ry);
            rd_vld_d = 1'b1;
          end
        end
        if (ld_q != 2'd0) begin
          cap = {pix(mem_data, cx + 1), pix(mem_data, cx), pix(mem_data, cx - 1)}
                & {3{rd_vld_q}};
          case (ld_q)
            2'd1:    begin nbr_d[DIR_NW] = cap[0]; nbr_d[DIR_N] = cap[1]; nbr_d[DIR_NE] = cap[2]; end
            2'd2:    begin nbr_d[DIR_W]  = cap[0]; nbr_d[DIR_E] = cap[2]; end
            default: begin nbr_d[DIR_SW] = cap[0]; nbr_d[DIR_S] = cap[1]; nbr_d[DIR_SE] = cap[2]; end
          endcase
        end
        if (ld_q == 2'd3) state_d = ST_SEARCH;
        ld_d = ld_q + 2'd1;
      end

      ST_SEARCH: begin
        // Back at the start and about to repeat the first move: loop closed.
        if (!sel_found ||
            (emitted_q && cur_x_q == start_x_q && cur_y_q == start_y_q &&
             sel_d == first_code_q)) begin
          area2_d = AREA_W'(acc_q[ACC_W-1] ? -acc_q : acc_q);
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (sel_d[0] ? (&perim_odd_q) : (&perim_even_q)) begin
          area2_d = AREA_W'(acc_q[ACC_W-1] ? -acc_q : acc_q);
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          code_d  = sel_d;
          state_d = ST_EMIT;
        end
      end

      ST_EMIT: begin
        if (code_ready) begin
          dx = dir_dx(code_q);
          dy = dir_dy(code_q);
          if (code_q[0]) perim_odd_d  = perim_odd_q + 1'b1;
          else           perim_even_d = perim_even_q + 1'b1;
          acc_d    = acc_q + ACC_W'(int'(cur_x_q) * dy - int'(cur_y_q) * dx);
          cur_x_d  = COORD_W'(int'(cur_x_q) + dx);
          cur_y_d  = COORD_W'(int'(cur_y_q) + dy);
          d_prev_d = code_q;
          if (!emitted_q) begin
            first_code_d = code_q;
            emitted_d    = 1'b1;
          end
          ld_d    = 2'd0;
          state_d = ST_LOAD;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any trace in progress.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      scan_row_q   <= '0;
      scan_last_q  <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_row_q     <= '0;
      ld_q         <= '0;
      nbr_q        <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      start_x_q    <= '0;
      start_y_q    <= '0;
      d_prev_q     <= '0;
      code_q       <= '0;
      first_code_q <= '0;
      emitted_q    <= 1'b0;
      perim_even_q <= '0;
      perim_odd_q  <= '0;
      acc_q        <= '0;
      area2_q      <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      scan_row_q   <= scan_row_d;
      scan_last_q  <= scan_last_d;
      rd_vld_q     <= rd_vld_d;
      rd_row_q     <= rd_row_d;
      ld_q         <= ld_d;
      nbr_q        <= nbr_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      start_x_q    <= start_x_d;
      start_y_q    <= start_y_d;
      d_prev_q     <= d_prev_d;
      code_q       <= code_d;
      first_code_q <= first_code_d;
      emitted_q    <= emitted_d;
      perim_even_q <= perim_even_d;
      perim_odd_q  <= perim_odd_d;
      acc_q        <= acc_d;
      area2_q      <= area2_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign code_valid = (state_q == ST_EMIT);
  assign code       = code_q;
  assign busy       = (state_q == ST_SCAN) || (state_q == ST_LOAD) ||
                      (state_q == ST_SEARCH) || (state_q == ST_EMIT);
  assign done       = done_q;
  assign error      = error_q;
  assign start_x    = start_x_q;
  assign start_y    = start_y_q;
  assign perim_even = perim_even_q;
  assign perim_odd  = perim_odd_q;
  assign area2      = area2_q;

endmodule
